spike_dispatcher: RTL and testbench

- Downstream consumer of the spike-event byte queue.
- Pops 8-bit presynaptic neuron IDs from the queue one at a time.
- For each ID, emits NUM_POST synapse events (pre ID, post index, weight-memory address) over a valid/ready stream to the synapse accumulator stage.
- Absorbs the queue's quirks: SRAM read latency, insert-over-read priority, and no underflow protection.

---
 rtl/spike_dispatcher.sv | 85 ++++++++
 tb/tb_spike_dispatcher.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_dispatcher.sv
// spike_dispatcher: pops presynaptic IDs from the spike queue and fans each one out
// into NUM_POST synapse events (pre, post, weight address) on a valid/ready stream.
module spike_dispatcher #(
    parameter int NUM_POST   = 32,
    parameter int POST_W     = 5,
    parameter int ADDR_W     = 13,
    parameter int FETCH_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              q_valid_i,
    input  logic [7:0]        q_data_i,
    input  logic              q_insert_i,
    output logic              q_read_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [7:0]        out_pre_o,
    output logic [POST_W-1:0] out_post_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic              out_last_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, WAIT, POP, DISPATCH} state_t;
    localparam int WAIT_W = $clog2(FETCH_WAIT + 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              hs, start;

    // The queue drops a read that coincides with an insert, so only pop when no insert is pending.
    assign q_read_o = state == POP && !q_insert_i && q_valid_i;
    assign busy_o   = state != IDLE;
    assign hs       = out_valid_o && out_ready_i;
    assign start    = enable_i && q_valid_i;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] pre, input logic [POST_W-1:0] post);
        return ADDR_W'(32'(pre) * NUM_POST + 32'(post));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            out_valid_o <= 1'b0;
            out_pre_o   <= '0;
            out_post_o  <= '0;
            out_addr_o  <= '0;
            out_last_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= WAIT;
                    wait_cnt <= WAIT_W'(FETCH_WAIT);
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_W'(1)) state <= POP;
                end
                POP: begin
                    out_pre_o <= q_data_i;
                    if (q_read_o) begin
                        state       <= DISPATCH;
                        out_valid_o <= 1'b1;
                        out_post_o  <= '0;
                        out_addr_o  <= addr_of(q_data_i, '0);
                        out_last_o  <= NUM_POST == 1;
                    end
                end
                DISPATCH: if (hs) begin
                    if (out_last_o) begin
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                        state       <= start ? WAIT : IDLE;
                        wait_cnt    <= WAIT_W'(FETCH_WAIT);
                    end else begin
                        out_post_o <= out_post_o + 1'b1;
                        out_addr_o <= addr_of(out_pre_o, out_post_o + 1'b1);
                        out_last_o <= out_post_o == POST_W'(NUM_POST - 2);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spike_dispatcher.sv
// tb_spike_dispatcher: directed + randomized bench; models the spike queue as a byte FIFO
// and the expected output as a flat list of (pre, post, addr, last) events per pushed ID.
module tb_spike_dispatcher;
    localparam int NUM_POST = 32, POST_W = 5, ADDR_W = 13, FETCH_WAIT = 2;

    logic              clk = 0, rst = 1, enable_i = 0, q_valid_i = 0, q_insert_i = 0, out_ready_i = 0;
    logic [7:0]        q_data_i = 8'hEE;
    logic              q_read_o, out_valid_o, out_last_o, busy_o;
    logic [7:0]        out_pre_o;
    logic [POST_W-1:0] out_post_o;
    logic [ADDR_W-1:0] out_addr_o;

    spike_dispatcher #(.NUM_POST(NUM_POST), .POST_W(POST_W), .ADDR_W(ADDR_W), .FETCH_WAIT(FETCH_WAIT)) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .q_valid_i(q_valid_i), .q_data_i(q_data_i),
        .q_insert_i(q_insert_i), .q_read_o(q_read_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pre_o(out_pre_o), .out_post_o(out_post_o), .out_addr_o(out_addr_o), .out_last_o(out_last_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo[$];
    logic [31:0] exp_q[$];
    logic [31:0] hold_vec;
    int n_cmp = 0, n_bad = 0, n_pops = 0, cyc = 0, seen = 0, last_cyc = 0;
    int rdy_mode = 0, ins_rate = 0;
    bit hold_pend = 0, exp_gap = 0, prev_valid = 0, rd_seen = 0;

    function automatic logic [31:0] ev(input int id, input int p);
        return {5'b0, 8'(id), POST_W'(p), ADDR_W'((id * NUM_POST + p) % (1 << ADDR_W)), 1'(p == NUM_POST - 1)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_id(input logic [7:0] id);
        fifo.push_back(id);
        for (int p = 0; p < NUM_POST; p++) exp_q.push_back(ev(id, p));
        q_valid_i = 1'b1;
    endtask

    // One clock: check at the falling edge, then update the queue model just after the rising edge.
    task automatic cycle();
        logic [31:0] vec;
        @(negedge clk);
        vec = {5'b0, out_pre_o, out_post_o, out_addr_o, out_last_o};
        rd_seen = q_read_o;
        if (q_read_o) chk("read_ok", {29'b0, q_valid_i, q_insert_i, busy_o}, 32'b101);
        if (hold_pend) chk("hold", vec, hold_vec);
        if (out_valid_o && !prev_valid && exp_gap) begin
            chk("gap", cyc - last_cyc - 1, FETCH_WAIT + 1);
            exp_gap = 0;
        end
        if (out_valid_o && out_ready_i && !rst) begin
            chk("event", vec, exp_q.size() != 0 ? exp_q.pop_front() : 32'hFFFF_FFFF);
            seen = out_last_o ? 0 : seen + 1;
            if (out_last_o) begin
                exp_gap  = q_valid_i && enable_i;
                last_cyc = cyc;
            end
        end
        if (q_insert_i || rst) exp_gap = 0;
        hold_pend  = out_valid_o && !out_ready_i && !rst;
        hold_vec   = vec;
        prev_valid = out_valid_o;
        @(posedge clk);
        #1;
        cyc++;
        q_data_i = fifo.size() != 0 ? fifo[0] : 8'hEE;
        if (rd_seen && !q_insert_i) begin
            fifo.delete(0);
            n_pops++;
        end
        if (q_insert_i) push_id(8'($urandom));
        q_valid_i = fifo.size() != 0;
        if (ins_rate > 0) q_insert_i = $urandom_range(0, ins_rate - 1) == 0;
        if (rdy_mode == 0) out_ready_i = 1'b1;
        else if (rdy_mode == 1) out_ready_i = !out_ready_i;
        else if (rdy_mode == 2) out_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_busy", busy_o, 0);
    endtask

    initial begin
        int lat, p0;
        repeat (2) cycle();
        chk("rst_out", {out_valid_o, q_read_o, busy_o, out_last_o, out_pre_o, out_post_o, out_addr_o}, 0);
        rst = 0;
        enable_i = 1;
        out_ready_i = 1;

        // single spike, continuous ready, first-event latency
        p0 = n_pops;
        push_id(8'd5);
        lat = 0;
        while (!out_valid_o && lat < 20) begin cycle(); lat++; end
        chk("latency", lat, FETCH_WAIT + 2);
        drain(200);
        chk("pops_one", n_pops - p0, 1);

        // two spikes with toggling ready
        rdy_mode = 1;
        p0 = n_pops;
        push_id(8'd5);
        push_id(8'd200);
        drain(400);
        chk("pops_two", n_pops - p0, 2);

        // insert held over three POP cycles
        rdy_mode = 0;
        out_ready_i = 1;
        p0 = n_pops;
        push_id(8'd42);
        repeat (3) cycle();
        q_insert_i = 1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("ins_read_low", q_read_o, 0);
            cycle();
        end
        q_insert_i = 0;
        #1;
        chk("ins_read_go", q_read_o, 1);
        cycle();
        chk("ins_pops", n_pops - p0, 1);
        chk("ins_qsize", fifo.size(), 3);
        drain(600);

        // empty queue
        repeat (100) begin
            cycle();
            chk("empty", {q_read_o, out_valid_o, busy_o}, 0);
        end

        // reset mid-dispatch
        p0 = n_pops;
        push_id(8'd7);
        push_id(8'd11);
        lat = 0;
        while (!(out_valid_o && out_post_o == 10) && lat < 100) begin cycle(); lat++; end
        chk("reach_post10", {out_valid_o, out_pre_o, out_post_o}, {1'b1, 8'd7, POST_W'(10)});
        rdy_mode = 3;
        out_ready_i = 0;
        rst = 1;
        cycle();
        chk("rst_mid", {out_valid_o, q_read_o, busy_o, out_last_o, out_pre_o, out_post_o, out_addr_o}, 0);
        rst = 0;
        repeat (NUM_POST - seen) exp_q.delete(0);
        seen = 0;
        rdy_mode = 0;
        out_ready_i = 1;
        drain(300);
        chk("rst_pops", n_pops - p0, 2);

        // enable gating
        enable_i = 0;
        p0 = n_pops;
        push_id(8'd3);
        repeat (10) cycle();
        chk("en_nopop", n_pops - p0, 0);
        chk("en_idle", busy_o, 0);
        enable_i = 1;
        lat = 0;
        #1;
        while (!q_read_o && lat < 20) begin cycle(); lat++; end
        chk("en_lat", lat, FETCH_WAIT + 1);
        lat = 0;
        while (!(out_valid_o && out_post_o == 4) && lat < 100) begin cycle(); lat++; end
        enable_i = 0;
        push_id(8'd4);
        repeat (60) cycle();
        chk("en_pops", n_pops - p0, 1);
        chk("en_left", exp_q.size(), NUM_POST);
        chk("en_busy", busy_o, 0);
        enable_i = 1;
        drain(200);

        // randomized traffic: random IDs, random ready, occasional inserts
        rdy_mode = 2;
        ins_rate = 64;
        repeat (8) push_id(8'($urandom));
        repeat (1500) cycle();
        ins_rate = 0;
        q_insert_i = 0;
        drain(4000);
        chk("rand_fifo", fifo.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
